// File: rtl/lbp_pkg.sv
// ============================================================================
//  Module      : lbp_pkg
//  Description : Shared types and constants for the LBP sequencing controller:
//                state encoding, window slot tables and fetch counts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SLIDE = 3'd2,
        ST_FILL  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } lbp_state_e;

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;

    localparam logic [3:0] INIT_FETCHES     = 4'd9;
    localparam logic [3:0] SLIDE_FETCHES    = 4'd3;
    localparam logic [3:0] SLIDE_FIRST_SLOT = 4'd6;

    // Slot layout is column-major: slot = col*3 + row, so dx = col-1, dy = row-1.
    function automatic logic [1:0] slot_col(input logic [3:0] slot);
        logic [1:0] col;
        case (slot)
            4'd0, 4'd1, 4'd2: col = 2'd0;
            4'd3, 4'd4, 4'd5: col = 2'd1;
            default:          col = 2'd2;
        endcase
        return col;
    endfunction

    function automatic logic [1:0] slot_row(input logic [3:0] slot);
        logic [1:0] row;
        case (slot)
            4'd0, 4'd3, 4'd6: row = 2'd0;
            4'd1, 4'd4, 4'd7: row = 2'd1;
            default:          row = 2'd2;
        endcase
        return row;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lbp_addr_gen.sv
// ============================================================================
//  Module      : lbp_addr_gen
//  Description : Centre x/y counters, row-end / last-centre / border detection
//                and gray-read / LBP-result address generation.
//                Optional macro LBP_BORDER_EN extends traversal to the border.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbp_addr_gen
    import lbp_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [1:0]        col,
    input  logic [1:0]        row,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] centre_addr,
    output logic              row_end,
    output logic              last,
    output logic              cur_border,
    output logic              next_border
);

    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
`ifdef LBP_BORDER_EN
    localparam logic [ADDR_W-1:0] X_FIRST = '0;
    localparam logic [ADDR_W-1:0] Y_FIRST = '0;
    localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 1);
`else
    localparam logic [ADDR_W-1:0] X_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] Y_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 2);
`endif

    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_y;
    logic [ADDR_W-1:0] w_fx;
    logic [ADDR_W-1:0] w_fy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= X_FIRST;
            r_y <= Y_FIRST;
        end else if (advance && !last) begin
            if (row_end) begin
                r_x <= X_FIRST;
                r_y <= r_y + ADDR_W'(1);
            end else begin
                r_x <= r_x + ADDR_W'(1);
            end
        end
    end

    assign row_end = (r_x == X_LAST);
    assign last    = row_end && (r_y == Y_LAST);

    // Offsets are applied as +col-1 / +row-1; interior centres never wrap.
    assign w_fx        = r_x + ADDR_W'(col) - ADDR_W'(1);
    assign w_fy        = r_y + ADDR_W'(row) - ADDR_W'(1);
    assign fetch_addr  = w_fy * W_A + w_fx;
    assign centre_addr = r_y * W_A + r_x;

`ifdef LBP_BORDER_EN
    assign cur_border  = (r_x == '0) || (r_y == '0) || (r_x == X_LAST) || (r_y == Y_LAST);
    // A row end always wraps to x=0, which is a border column.
    assign next_border = row_end || (r_y == '0) || (r_y == Y_LAST) || (r_x == X_LAST - ADDR_W'(1));
`else
    assign cur_border  = 1'b0;
    assign next_border = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/lbp_seq_ctrl.sv
// ============================================================================
//  Module      : lbp_seq_ctrl
//  Description : Raster sequencer for the LBP engine: gray-memory fetches,
//                window write strobes and LBP result handshake.
//                Optional macro LBP_BORDER_EN writes border pixels as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbp_seq_ctrl
    import lbp_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              win_wr_en,
    output logic [3:0]        win_wr_idx,
    output logic              win_shift,
    output logic              lbp_valid,
    input  logic              lbp_ready,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_zero,
    output logic              finish
);

    lbp_state_e        r_state;
    lbp_state_e        w_next;
    logic [3:0]        r_fetch_cnt;
    logic [3:0]        w_fetch_cnt_nxt;
    logic              w_shift;
    logic              w_fetching;
    logic              w_accept;
    logic              w_xfer;
    logic [3:0]        w_slot;
    logic              r_win_wr_en;
    logic [3:0]        r_win_wr_idx;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [ADDR_W-1:0] w_centre_addr;
    logic              w_row_end;
    logic              w_last;
    logic              w_cur_border;
    logic              w_next_border;

    assign w_fetching = (r_state == ST_INIT) || (r_state == ST_SLIDE);
    assign w_accept   = w_fetching && gray_ready;
    assign w_xfer     = (r_state == ST_WRITE) && lbp_ready;
    assign w_slot     = (r_state == ST_SLIDE) ? (SLIDE_FIRST_SLOT + r_fetch_cnt) : r_fetch_cnt;

    lbp_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .advance     (w_xfer),
        .col         (slot_col(w_slot)),
        .row         (slot_row(w_slot)),
        .fetch_addr  (w_fetch_addr),
        .centre_addr (w_centre_addr),
        .row_end     (w_row_end),
        .last        (w_last),
        .cur_border  (w_cur_border),
        .next_border (w_next_border)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_fetch_cnt  <= 4'd0;
            r_win_wr_en  <= 1'b0;
            r_win_wr_idx <= 4'd0;
        end else begin
            r_state      <= w_next;
            r_fetch_cnt  <= w_fetch_cnt_nxt;
            r_win_wr_en  <= w_accept;
            r_win_wr_idx <= w_accept ? w_slot : 4'd0;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_shift         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (gray_ready) begin
                    w_next = w_cur_border ? ST_WRITE : ST_INIT;
                end
            end
            ST_INIT: begin
                if (w_accept) begin
                    if (r_fetch_cnt == INIT_FETCHES - 4'd1) begin
                        w_next          = ST_FILL;
                        w_fetch_cnt_nxt = 4'd0;
                    end else begin
                        w_fetch_cnt_nxt = r_fetch_cnt + 4'd1;
                    end
                end
            end
            ST_SLIDE: begin
                if (w_accept) begin
                    if (r_fetch_cnt == SLIDE_FETCHES - 4'd1) begin
                        w_next          = ST_FILL;
                        w_fetch_cnt_nxt = 4'd0;
                    end else begin
                        w_fetch_cnt_nxt = r_fetch_cnt + 4'd1;
                    end
                end
            end
            ST_FILL: w_next = ST_WRITE;
            ST_WRITE: begin
                // Only an interior-to-interior step within one row reuses the window.
                if (lbp_ready) begin
                    if (w_last) begin
                        w_next = ST_DONE;
                    end else if (w_next_border) begin
                        w_next = ST_WRITE;
                    end else if (w_row_end || w_cur_border) begin
                        w_next = ST_INIT;
                    end else begin
                        w_next  = ST_SLIDE;
                        w_shift = 1'b1;
                    end
                end
            end
            ST_DONE: w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign gray_req   = w_accept;
    assign gray_addr  = w_accept ? w_fetch_addr : '0;
    assign win_wr_en  = r_win_wr_en;
    assign win_wr_idx = r_win_wr_idx;
    assign win_shift  = w_shift;
    assign lbp_valid  = (r_state == ST_WRITE);
    assign lbp_addr   = lbp_valid ? w_centre_addr : '0;
    assign lbp_zero   = lbp_valid && w_cur_border;
    assign finish     = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lbp_seq_ctrl.sv
// ============================================================================
//  Module      : tb_lbp_seq_ctrl
//  Description : Scoreboard bench for lbp_seq_ctrl (4x4 and 5x3 instances);
//                adapts its reference model when LBP_BORDER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lbp_seq_ctrl;

    localparam int AW = 4;
    localparam int AH = 4;
    localparam int BW = 5;
    localparam int BH = 3;
`ifdef LBP_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       gray_ready = 1'b0;
    logic       lbp_ready = 1'b0;
    logic       gray_req, win_wr_en, win_shift, lbp_valid, lbp_zero, finish;
    logic [3:0] gray_addr, win_wr_idx, lbp_addr;
    logic       b_gray_ready = 1'b1;
    logic       b_lbp_ready = 1'b1;
    logic       b_gray_req, b_win_wr_en, b_win_shift, b_lbp_valid, b_lbp_zero, b_finish;
    logic [3:0] b_gray_addr, b_win_wr_idx, b_lbp_addr;

    always #5 clk = ~clk;

    lbp_seq_ctrl #(.IMG_W(AW), .IMG_H(AH), .ADDR_W(4)) dut_a (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
        .gray_addr(gray_addr), .win_wr_en(win_wr_en), .win_wr_idx(win_wr_idx),
        .win_shift(win_shift), .lbp_valid(lbp_valid), .lbp_ready(lbp_ready),
        .lbp_addr(lbp_addr), .lbp_zero(lbp_zero), .finish(finish)
    );

    lbp_seq_ctrl #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(4)) dut_b (
        .clk(clk), .reset(reset), .gray_ready(b_gray_ready), .gray_req(b_gray_req),
        .gray_addr(b_gray_addr), .win_wr_en(b_win_wr_en), .win_wr_idx(b_win_wr_idx),
        .win_shift(b_win_shift), .lbp_valid(b_lbp_valid), .lbp_ready(b_lbp_ready),
        .lbp_addr(b_lbp_addr), .lbp_zero(b_lbp_zero), .finish(b_finish)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_gaddr[$];
    int exp_slot[$];
    int exp_lbp[$];
    int exp_zero[$];
    int exp_shift[$];
    int exp_b[$];
    int exp_cycles;
    bit mon_en = 1'b0;
    int n_acc, n_xfer, t_start, t_last, pend_slot, hold_addr;
    bit prev_acc, prev_hold;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list the centres in raster order, then derive fetches and timing
    // from whether each centre reuses the previous window.
    task automatic build_model();
        int cx[$];
        int cy[$];
        int cb[$];
        int lo_x, hi_x, lo_y, hi_y;
        bit slide, nxt;
        exp_gaddr.delete(); exp_slot.delete(); exp_lbp.delete();
        exp_zero.delete(); exp_shift.delete(); exp_b.delete();
        lo_x = BORDER ? 0 : 1;  hi_x = BORDER ? AW - 1 : AW - 2;
        lo_y = BORDER ? 0 : 1;  hi_y = BORDER ? AH - 1 : AH - 2;
        for (int y = lo_y; y <= hi_y; y++)
            for (int x = lo_x; x <= hi_x; x++) begin
                cx.push_back(x); cy.push_back(y);
                cb.push_back((x == 0 || y == 0 || x == AW - 1 || y == AH - 1) ? 1 : 0);
            end
        exp_cycles = 0;
        for (int i = 0; i < cx.size(); i++) begin
            slide = (i > 0) && (cb[i] == 0) && (cb[i-1] == 0) && (cy[i-1] == cy[i]);
            if (cb[i] != 0) begin
                exp_cycles += 1;
            end else if (slide) begin
                for (int r = 0; r < 3; r++) begin
                    exp_gaddr.push_back((cy[i] - 1 + r) * AW + cx[i] + 1);
                    exp_slot.push_back(6 + r);
                end
                exp_cycles += 5;
            end else begin
                for (int c = 0; c < 3; c++)
                    for (int r = 0; r < 3; r++) begin
                        exp_gaddr.push_back((cy[i] - 1 + r) * AW + cx[i] - 1 + c);
                        exp_slot.push_back(c * 3 + r);
                    end
                exp_cycles += 11;
            end
            nxt = (i + 1 < cx.size()) && (cb[i] == 0) && (cb[i+1] == 0) && (cy[i+1] == cy[i]);
            exp_lbp.push_back(cy[i] * AW + cx[i]);
            exp_zero.push_back(cb[i]);
            exp_shift.push_back(nxt ? 1 : 0);
        end
        for (int y = (BORDER ? 0 : 1); y <= (BORDER ? BH - 1 : BH - 2); y++)
            for (int x = (BORDER ? 0 : 1); x <= (BORDER ? BW - 1 : BW - 2); x++)
                exp_b.push_back(y * BW + x);
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (!gray_ready) check("gray_req_while_not_ready", gray_req, 0);
            check("win_wr_en_lag", win_wr_en, prev_acc);
            if (win_wr_en && prev_acc) check("win_wr_idx", win_wr_idx, pend_slot);
            if (gray_req && gray_ready) begin
                n_acc++;
                if (exp_gaddr.size() == 0) check("gray_extra_accept", 1, 0);
                else begin
                    check("gray_addr", gray_addr, exp_gaddr.pop_front());
                    pend_slot = exp_slot.pop_front();
                end
            end
            prev_acc = gray_req && gray_ready;
            if (prev_hold) begin
                check("lbp_valid_held", lbp_valid, 1);
                check("lbp_addr_stable", lbp_addr, hold_addr);
            end
            if (lbp_valid && !lbp_ready) check("win_shift_while_stalled", win_shift, 0);
            if (lbp_valid && lbp_ready) begin
                n_xfer++;
                t_last = cyc;
                if (exp_lbp.size() == 0) check("lbp_extra_transfer", 1, 0);
                else begin
                    check("lbp_addr", lbp_addr, exp_lbp.pop_front());
                    check("lbp_zero", lbp_zero, exp_zero.pop_front());
                    check("win_shift", win_shift, exp_shift.pop_front());
                end
            end
            prev_hold = lbp_valid && !lbp_ready;
            hold_addr = lbp_addr;
            if (b_lbp_valid) begin
                if (exp_b.size() == 0) check("b_extra_transfer", 1, 0);
                else check("b_lbp_addr", b_lbp_addr, exp_b.pop_front());
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b0;
        gray_ready = 1'b0;
        lbp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_a", int'({gray_req, gray_addr, win_wr_en, win_wr_idx, win_shift,
                                       lbp_valid, lbp_addr, lbp_zero, finish}), 0);
        check("reset_finish_b", b_finish, 0);
        build_model();
        n_acc = 0; n_xfer = 0; prev_acc = 1'b0; prev_hold = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    // mode 0: always ready, 1: gray stall, 2: lbp backpressure, 3: random
    task automatic run_phase(input int mode);
        int stall_left = 2;
        int bp_left = 3;
        int guard = 0;
        do_reset();
        @(posedge clk);
        #1;
        t_start = cyc;
        gray_ready = 1'b1;
        lbp_ready = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (!finish && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
            if (mode == 1) begin
                if (n_acc == 4 && stall_left > 0) begin
                    gray_ready = 1'b0; stall_left--;
                end else gray_ready = 1'b1;
            end else if (mode == 2) begin
                if (lbp_valid && bp_left > 0) begin
                    lbp_ready = 1'b0; bp_left--;
                end else lbp_ready = 1'b1;
            end else if (mode == 3) begin
                gray_ready = ($urandom_range(0, 3) != 0);
                lbp_ready = ($urandom_range(0, 3) != 0);
            end
        end
        check("finish_reached", finish, 1);
        check("b_finish", b_finish, 1);
        if (mode == 1) check("cycles_gray_stall", t_last - t_start, exp_cycles + 2);
        else if (mode == 2) check("cycles_backpressure", t_last - t_start, exp_cycles + 3);
        else if (mode == 0) check("cycles_no_stall", t_last - t_start, exp_cycles);
        check("gray_fetches_left", exp_gaddr.size(), 0);
        check("lbp_writes_left", exp_lbp.size(), 0);
        check("b_writes_left", exp_b.size(), 0);
        gray_ready = 1'b1;
        lbp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done_quiet", int'({gray_req, lbp_valid, win_wr_en}), 0);
        check("finish_sticky", finish, 1);
    endtask

    task automatic mid_reset();
        int guard = 0;
        do_reset();
        @(posedge clk);
        #1;
        gray_ready = 1'b1;
        lbp_ready = 1'b1;
        while (n_xfer < 3 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("mid_reset_reached", n_xfer, 3);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_reset_outputs_a", int'({gray_req, gray_addr, win_wr_en, win_wr_idx, win_shift,
                                           lbp_valid, lbp_addr, lbp_zero, finish}), 0);
        check("mid_reset_outputs_b", int'({b_gray_req, b_win_wr_en, b_lbp_valid, b_finish}), 0);
    endtask

    initial begin
        run_phase(0);
        run_phase(1);
        run_phase(2);
        mid_reset();
        run_phase(0);
        for (int k = 0; k < 4; k++) run_phase(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
